// File: rtl/sign_tracker.sv
// sign_tracker: classifies each accepted sample by sign and zero-ness.
// It also tracks sign changes and the saturating run length of same-sign samples.
module sign_tracker #(
  parameter int unsigned N           = 8,
  parameter int unsigned CW          = 4,
  parameter int unsigned SIGNED_MODE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [N-1:0]  number,
  output logic          out_valid,
  output logic [N-1:0]  held,
  output logic          num_signal,
  output logic          is_zero,
  output logic          sign_change,
  output logic [CW-1:0] run_len,
  output logic          first
);

  localparam logic [CW-1:0] RUN_MAX = '1;
  localparam logic [CW-1:0] RUN_ONE = CW'(1);

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t state;

  // Sign of the incoming sample; zero counts as non-negative, unsigned input is never negative
  logic new_sign_c;
  assign new_sign_c = (SIGNED_MODE != 0) ? number[N-1] : 1'b0;

  // Tracker FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      held        <= '0;
      num_signal  <= 1'b0;
      is_zero     <= 1'b0;
      sign_change <= 1'b0;
      run_len     <= '0;
      first       <= 1'b0;
    end else if (clear) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      held        <= '0;
      num_signal  <= 1'b0;
      is_zero     <= 1'b0;
      sign_change <= 1'b0;
      run_len     <= '0;
      first       <= 1'b0;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      held       <= number;
      num_signal <= new_sign_c;
      is_zero    <= (number == '0);
      case (state)
        EMPTY: begin
          first       <= 1'b1;
          run_len     <= RUN_ONE;
          sign_change <= 1'b0;
          state       <= TRACK;
        end
        TRACK: begin
          first <= 1'b0;
          if (new_sign_c == num_signal) begin
            sign_change <= 1'b0;
            if (run_len != RUN_MAX) begin
              run_len <= run_len + RUN_ONE;
            end
          end else begin
            sign_change <= 1'b1;
            run_len     <= RUN_ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end else begin
      out_valid   <= 1'b0;
      sign_change <= 1'b0;
    end
  end

endmodule
